// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
// Streaming controller that walks a raster-scan grayscale frame and keeps two
// line buffers plus a 3x3 window register. The window is presented to an
// external combinational Sobel core. The core result comes back on sobel_i and
// is captured into a valid/ready output register. A small FSM tracks the frame.
//
// Optional feature macro: SOBEL_THRESHOLD_EN.
// When it is defined, the captured result is binarised against threshold_i.
//
// Ports:
//   clk_i, rst_i           clock and asynchronous active-high reset
//   start_i                one-cycle pulse; arms one frame (ignored unless idle)
//   busy_o / done_o        frame in progress / one-cycle end-of-frame pulse
//   pixel_i, pixel_valid_i, pixel_ready_o    input pixel stream
//   matrix_o               window to core, [r][c]; r=0 oldest row, c=2 newest
//                          column. Each element is PIXEL_WIDTH+1 bits: the pixel
//                          zero-extended so the signed core sees it as positive.
//   sobel_i                core result for matrix_o
//   threshold_i            binarisation threshold (SOBEL_THRESHOLD_EN only)
//   edge_o, edge_valid_o, edge_ready_i, edge_last_o   output result stream
module sobel_window_ctrl #(
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 48,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  output logic                               busy_o,
  output logic                               done_o,
  input  logic [PIXEL_WIDTH-1:0]             pixel_i,
  input  logic                               pixel_valid_i,
  output logic                               pixel_ready_o,
  output logic [2:0][2:0][PIXEL_WIDTH:0]     matrix_o,
  input  logic [PIXEL_WIDTH-1:0]             sobel_i,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIXEL_WIDTH-1:0]             threshold_i,
`endif
  output logic [PIXEL_WIDTH-1:0]             edge_o,
  output logic                               edge_valid_o,
  input  logic                               edge_ready_i,
  output logic                               edge_last_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pend_q, pend_d;
  logic                   pend_last_q, pend_last_d;
  logic [PIXEL_WIDTH-1:0] edge_q, edge_d;
  logic                   edge_valid_q, edge_valid_d;
  logic                   edge_last_q, edge_last_d;
  logic [2:0][2:0][PIXEL_WIDTH-1:0] win_q, win_d;

  logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];

  logic                   out_free_s;
  logic                   out_fire_s;
  logic                   in_fire_s;
  logic                   capture_s;
  logic                   win_ok_s;
  logic                   last_px_s;
  logic [PIXEL_WIDTH-1:0] cap_val_s;

  // The output register can take a new result when empty or being drained.
  // A pending result is only ever waiting while the output is blocked, and
  // then no new pixel is taken either, so the window cannot move under it.
  assign out_free_s    = !edge_valid_q || edge_ready_i;
  assign out_fire_s    = edge_valid_q && edge_ready_i;
  assign pixel_ready_o = (state_q == S_RUN) && out_free_s;
  assign in_fire_s     = pixel_valid_i && pixel_ready_o;
  assign capture_s     = pend_q && out_free_s;
  assign win_ok_s      = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign last_px_s     = (row_q == ROW_LAST) && (col_q == COL_LAST);

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign edge_o       = edge_q;
  assign edge_valid_o = edge_valid_q;
  assign edge_last_o  = edge_last_q;

  // Zero-extend the window into the core's signed input width.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        matrix_o[r][c] = {1'b0, win_q[r][c]};
      end
    end
  end

  // Value written into the output register when a pending result is captured.
  always_comb begin
`ifdef SOBEL_THRESHOLD_EN
    if (sobel_i >= threshold_i) begin
      cap_val_s = {PIXEL_WIDTH{1'b1}};
    end else begin
      cap_val_s = {PIXEL_WIDTH{1'b0}};
    end
`else
    cap_val_s = sobel_i;
`endif
  end

  // Frame FSM, position counters and the pending/output result pipeline.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pend_d       = pend_q;
    pend_last_d  = pend_last_q;
    edge_d       = edge_q;
    edge_valid_d = edge_valid_q;
    edge_last_d  = edge_last_q;

    // Output register: load a pending result, otherwise drain on handshake.
    if (capture_s) begin
      edge_d       = cap_val_s;
      edge_valid_d = 1'b1;
      edge_last_d  = pend_last_q;
      pend_d       = 1'b0;
      pend_last_d  = 1'b0;
    end else if (out_fire_s) begin
      edge_valid_d = 1'b0;
      edge_last_d  = 1'b0;
    end else begin
      edge_valid_d = edge_valid_q;
    end

    // A new pixel whose window is complete leaves a result pending; the core
    // sees the updated window next cycle and it is captured then.
    if (in_fire_s) begin
      pend_d      = win_ok_s;
      pend_last_d = last_px_s;
      if (last_px_s) begin
        col_d = {CW{1'b0}};
        row_d = {RW{1'b0}};
      end else if (col_q == COL_LAST) begin
        col_d = {CW{1'b0}};
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (in_fire_s && last_px_s) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (out_fire_s && edge_last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          col_d   = {CW{1'b0}};
          row_d   = {RW{1'b0}};
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Window shift: columns move left, the new column comes from the line
  // buffers (older rows) and the incoming pixel (newest row).
  always_comb begin
    win_d = win_q;
    if (in_fire_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1[col_q];
      win_d[1][2] = lb0[col_q];
      win_d[2][2] = pixel_i;
    end else begin
      win_d = win_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      edge_q       <= {PIXEL_WIDTH{1'b0}};
      edge_valid_q <= 1'b0;
      edge_last_q  <= 1'b0;
      win_q        <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      edge_q       <= edge_d;
      edge_valid_q <= edge_valid_d;
      edge_last_q  <= edge_last_d;
      win_q        <= win_d;
    end
  end

  // Line buffers: storage only, no reset; rows 0 and 1 of each frame are
  // written before any window that reads them is output.
  always_ff @(posedge clk_i) begin
    if (in_fire_s) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= pixel_i;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PW   = 8;
  localparam int NPIX = W * H;
  localparam int NRES = (W - 2) * (H - 2);

  logic                       clk = 1'b0;
  logic                       rst_i = 1'b1;
  logic                       start_i = 1'b0;
  logic                       busy_o, done_o;
  logic [PW-1:0]              pixel_i = '0;
  logic                       pixel_valid_i = 1'b0;
  logic                       pixel_ready_o;
  logic [2:0][2:0][PW:0]      matrix_o;
  logic [PW-1:0]              sobel_i;
  logic [PW-1:0]              threshold_i = 8'd128;
  logic [PW-1:0]              edge_o;
  logic                       edge_valid_o;
  logic                       edge_ready_i = 1'b1;
  logic                       edge_last_o;

  int tests_run = 0;
  int tests_failed = 0;

  int res_q[$];
  bit last_q[$];
  int cyc_q[$];
  int done_cnt, extra_out, stall_seen, stall_viol, ready_viol;
  bit timeout, busy_after_start;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i), .pixel_ready_o(pixel_ready_o),
    .matrix_o(matrix_o), .sobel_i(sobel_i),
`ifdef SOBEL_THRESHOLD_EN
    .threshold_i(threshold_i),
`endif
    .edge_o(edge_o), .edge_valid_o(edge_valid_o), .edge_ready_i(edge_ready_i),
    .edge_last_o(edge_last_o)
  );

  // Combinational Sobel core model: |gx|+|gy| saturated to the pixel width.
  int gx, gy, mag;
  always_comb begin
    gx = (int'(matrix_o[0][2]) + 2 * int'(matrix_o[1][2]) + int'(matrix_o[2][2]))
       - (int'(matrix_o[0][0]) + 2 * int'(matrix_o[1][0]) + int'(matrix_o[2][0]));
    gy = (int'(matrix_o[2][0]) + 2 * int'(matrix_o[2][1]) + int'(matrix_o[2][2]))
       - (int'(matrix_o[0][0]) + 2 * int'(matrix_o[0][1]) + int'(matrix_o[0][2]));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    sobel_i = (mag > 255) ? 8'd255 : mag[7:0];
  end

  // kind 0: uniform 100, kind 1: ramp col*10, kind 2: vertical step at col 4
  function automatic logic [PW-1:0] pixval(input int kind, input int idx);
    int col;
    col = idx % W;
    case (kind)
      0: pixval = 8'd100;
      1: pixval = 8'(col * 10);
      default: pixval = (col < 4) ? 8'd0 : 8'd200;
    endcase
  endfunction

  // Hand-computed expectations: ramp gives 4*20=80; step windows with the
  // newest column at 4 or 5 straddle the edge and saturate.
  function automatic int exp_ramp();
`ifdef SOBEL_THRESHOLD_EN
    exp_ramp = 0;
`else
    exp_ramp = 80;
`endif
  endfunction

  function automatic int exp_step(input int n);
    int c;
    c = (n % (W - 2)) + 2;
    exp_step = (c == 4 || c == 5) ? 255 : 0;
  endfunction

  // Drive one frame: start pulse, pixels, optional output stall and an
  // optional stray start_i during RUN; collect all output handshakes.
  task automatic do_frame(input int kind, input int stall_start, input int stall_len,
                          input int restart_at);
    int idx, cyc;
    bit held_set;
    logic [PW-1:0] held;
    res_q.delete(); last_q.delete(); cyc_q.delete();
    done_cnt = 0; extra_out = 0; stall_seen = 0; stall_viol = 0; ready_viol = 0;
    timeout = 1'b0; held_set = 1'b0; held = '0;
    @(negedge clk); start_i = 1'b1; pixel_valid_i = 1'b0; edge_ready_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    #1 busy_after_start = busy_o;
    idx = 0; cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_i       = (cyc == restart_at);
      pixel_valid_i = (idx < NPIX);
      pixel_i       = pixval(kind, idx);
      edge_ready_i  = !(cyc >= stall_start && cyc < stall_start + stall_len);
      #1;
      if (!edge_ready_i && edge_valid_o) begin
        stall_seen++;
        if (pixel_ready_o) ready_viol++;
        if (held_set && edge_o !== held) stall_viol++;
        held = edge_o; held_set = 1'b1;
      end else begin
        held_set = 1'b0;
      end
      if (edge_valid_o && edge_ready_i) begin
        res_q.push_back(int'(edge_o));
        last_q.push_back(edge_last_o);
        cyc_q.push_back(cyc);
      end
      if (done_o) done_cnt++;
      if (pixel_valid_i && pixel_ready_o) idx++;
    end
    if (done_cnt == 0) timeout = 1'b1;
    start_i = 1'b0; edge_ready_i = 1'b1;
    pixel_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (done_o) done_cnt++;
      if (edge_valid_o || pixel_ready_o) extra_out++;
    end
    pixel_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done_o); end
    tests_run++; if (pixel_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b exp 0", pixel_ready_o); end
    tests_run++; if (edge_valid_o !== 1'b0 || edge_last_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_last got %b%b exp 00", edge_valid_o, edge_last_o); end
    tests_run++; if (edge_o !== 8'd0) begin tests_failed++; $display("FAIL reset_edge got %0d exp 0", edge_o); end
    tests_run++; if (matrix_o !== '0) begin tests_failed++; $display("FAIL reset_matrix got %h exp 0", matrix_o); end
    @(negedge clk); rst_i = 1'b0;
    // pixels offered while idle must be refused and leave no trace
    pixel_valid_i = 1'b1; pixel_i = 8'd77;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (pixel_ready_o !== 1'b0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL idle_refuse ready=%b busy=%b exp 0 0", pixel_ready_o, busy_o); end
    pixel_valid_i = 1'b0;
  endtask

  task automatic test_uniform();
    int nz, nlast, lastpos;
    do_frame(0, 1000, 0, -1);
    nz = 0; nlast = 0; lastpos = -1;
    foreach (res_q[i]) begin
      if (res_q[i] != 0) nz++;
      if (last_q[i]) begin nlast++; lastpos = i; end
    end
    tests_run++; if (busy_after_start !== 1'b1) begin tests_failed++; $display("FAIL uni_busy got %b exp 1", busy_after_start); end
    tests_run++; if (timeout) begin tests_failed++; $display("FAIL uni_timeout got 1 exp 0"); end
    tests_run++; if (res_q.size() != NRES) begin tests_failed++; $display("FAIL uni_count got %0d exp %0d", res_q.size(), NRES); end
    tests_run++; if (nz != 0) begin tests_failed++; $display("FAIL uni_values nonzero got %0d exp 0", nz); end
    tests_run++; if (nlast != 1 || lastpos != NRES - 1) begin tests_failed++; $display("FAIL uni_last count %0d pos %0d exp 1 %0d", nlast, lastpos, NRES - 1); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL uni_done pulses got %0d exp 1", done_cnt); end
    tests_run++; if (extra_out != 0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL uni_idle_after extra=%0d busy=%b exp 0 0", extra_out, busy_o); end
  endtask

  task automatic test_ramp();
    int bad;
    do_frame(1, 1000, 0, -1);
    bad = 0;
    foreach (res_q[i]) if (res_q[i] != exp_ramp()) bad++;
    tests_run++; if (res_q.size() != NRES) begin tests_failed++; $display("FAIL ramp_count got %0d exp %0d", res_q.size(), NRES); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL ramp_values wrong %0d first %0d exp %0d", bad, (res_q.size() > 0) ? res_q[0] : -1, exp_ramp()); end
  endtask

  task automatic test_backpressure();
    int bad;
    do_frame(2, 30, 5, -1);
    bad = 0;
    foreach (res_q[i]) if (res_q[i] != exp_step(i)) bad++;
    tests_run++; if (res_q.size() != NRES) begin tests_failed++; $display("FAIL bp_count got %0d exp %0d", res_q.size(), NRES); end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bp_sequence wrong %0d exp 0", bad); end
    tests_run++; if (stall_seen < 4) begin tests_failed++; $display("FAIL bp_stall_seen got %0d exp >=4", stall_seen); end
    tests_run++; if (ready_viol != 0) begin tests_failed++; $display("FAIL bp_ready_drop got %0d ready cycles exp 0", ready_viol); end
    tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL bp_edge_stable got %0d changes exp 0", stall_viol); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad, badgap, span;
    do_frame(2, 1000, 0, 10);
    bad = 0; badgap = 0; span = -1;
    foreach (res_q[i]) if (res_q[i] != exp_step(i)) bad++;
    for (int i = 1; i < cyc_q.size(); i++)
      if ((cyc_q[i] - cyc_q[i-1]) != ((i % (W - 2) == 0) ? 3 : 1)) badgap++;
    if (cyc_q.size() > 0) span = cyc_q[cyc_q.size()-1] - cyc_q[0];
    tests_run++; if (res_q.size() != NRES || bad != 0) begin tests_failed++; $display("FAIL b2b_results count %0d wrong %0d exp %0d 0", res_q.size(), bad, NRES); end
    tests_run++; if (badgap != 0) begin tests_failed++; $display("FAIL b2b_gaps got %0d exp 0", badgap); end
    tests_run++; if (span != (NRES - 1) + 2 * (H - 3)) begin tests_failed++; $display("FAIL b2b_span got %0d exp %0d", span, (NRES - 1) + 2 * (H - 3)); end
    tests_run++; if (done_cnt != 1 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_done pulses %0d busy %b exp 1 0", done_cnt, busy_o); end
  endtask

  task automatic test_reset_midframe();
    int idx, cyc, bad;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 3 * W + 2 && cyc < 200) begin
      @(negedge clk); cyc++;
      pixel_valid_i = 1'b1; pixel_i = pixval(2, idx); edge_ready_i = 1'b1;
      #1;
      if (pixel_ready_o) idx++;
    end
    @(negedge clk);
    pixel_valid_i = 1'b0; rst_i = 1'b1;
    #1;
    tests_run++; if (busy_o !== 1'b0 || pixel_ready_o !== 1'b0 || done_o !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ctrl busy=%b ready=%b done=%b exp 0 0 0", busy_o, pixel_ready_o, done_o); end
    tests_run++; if (edge_valid_o !== 1'b0 || edge_last_o !== 1'b0 || edge_o !== 8'd0) begin tests_failed++; $display("FAIL mid_rst_out valid=%b last=%b edge=%0d exp 0 0 0", edge_valid_o, edge_last_o, edge_o); end
    @(negedge clk); rst_i = 1'b0;
    do_frame(1, 1000, 0, -1);
    bad = 0;
    foreach (res_q[i]) if (res_q[i] != exp_ramp()) bad++;
    tests_run++; if (res_q.size() != NRES || bad != 0) begin tests_failed++; $display("FAIL mid_rst_frame count %0d wrong %0d exp %0d 0", res_q.size(), bad, NRES); end
    tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL mid_rst_done got %0d exp 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
